line_column_feeder: RTL
=======================

LINE_COLUMN_FEEDER -- requirements
Module: line_column_feeder

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, pixels per line (>=2).
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, lines per frame (>=3).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  input pixel present this cycle.
REQ-006 SHALL have port i_data  input  8  unsigned raster-order pixel.
REQ-007 SHALL have port i_done  input  1  marks the last pixel of a frame; sampled only with i_valid.
REQ-008 SHALL have port o_ready  output  1  high when an input pixel can be accepted.
REQ-009 SHALL have port o_valid  output  1  o_data holds a valid 3-pixel column.
REQ-010 SHALL have port o_data  output  24  {[23:16] row r-1, [15:8] row r (centre), [7:0] row r+1}, same column index.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse coincident with the last column of a frame.
REQ-012 SHALL have port o_err  output  1  sticky; frame-length mismatch detected.

Function
REQ-013 SHALL accept a pixel when i_valid && o_ready; pixels with o_ready low are dropped.
REQ-014 SHALL hold two line buffers of IMG_WIDTH x 8 bits: lines y-1 and y-2 relative to the current input line y.
REQ-015 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1); col wraps to 0 and row increments at col=IMG_WIDTH-1.
REQ-016 SHALL use states FILL (rows 0..1), STREAM (rows 2..IMG_HEIGHT-1), FLUSH (padding only, REQ-028).
REQ-017 In STREAM, each accepted pixel (row y, col x) SHALL produce o_data={buf y-2[x], buf y-1[x], i_data} with o_valid high exactly 1 cycle after acceptance.
REQ-018 In FILL, accepted pixels SHALL only be written to the line buffers; o_valid stays low.
REQ-019 A line-buffer write and read at the same address in the same cycle SHALL return the old (pre-write) data.
REQ-020 o_valid SHALL be low on any cycle following a cycle with no accepted pixel (and no FLUSH column).
REQ-021 Acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL end the frame: o_done pulses with its column; counters return to 0, state to FILL (non-pad).
REQ-022 i_done accepted at any other position SHALL set o_err, end the frame without an o_done pulse, and return counters/state to 0/FILL.
REQ-023 Missing i_done at the final pixel SHALL set o_err; the frame still ends per REQ-021.
REQ-024 o_ready SHALL be high in FILL and STREAM.

Reset
REQ-025 On reset low, immediately: o_valid=0, o_done=0, o_err=0, o_data=0, o_ready=0, col=0, row=0, state=FILL.
REQ-026 o_ready SHALL go high the first cycle after reset deasserts; line-buffer contents need not be cleared.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the next accepted pixel is (0,0).

Configuration
REQ-028 Macro LINE_COLUMN_FEEDER_PAD_EN defined: output SHALL be IMG_WIDTH x IMG_HEIGHT columns with zero borders. Row 1 input emits centre row 0 with [23:16]=0. Each row y>=2 emits centre y-1. After the final pixel, state FLUSH, o_ready=0, and IMG_WIDTH consecutive cycles emit centre row IMG_HEIGHT-1 with [7:0]=0. o_done pulses on the last FLUSH column; then FILL (row 0 only fills).
REQ-029 Macro undefined: SHALL emit IMG_WIDTH x (IMG_HEIGHT-2) columns per REQ-017; no FLUSH state is implemented.

Verification
REQ-030 IMG_WIDTH=4, IMG_HEIGHT=3, no pad, pixels 1..12 contiguous, i_done on 12 -> 4 columns {1,5,9},{2,6,10},{3,7,11},{4,8,12}, each 1 cycle after input; o_done with {4,8,12}; o_err=0.
REQ-031 Same frame with i_valid toggling every other cycle -> identical columns, o_valid only one cycle after each accepted pixel.
REQ-032 i_done on pixel 7 -> o_err=1, no o_done; next frame 1..12 -> correct columns per REQ-030.
REQ-033 Reset low after pixel 9 -> outputs 0 at once; after release, frame 1..12 -> columns per REQ-030.
REQ-034 PAD_EN, 4x3, pixels 1..12 -> 12 columns: {0,1,5}..{0,4,8}, {1,5,9}..{4,8,12}, then 4 FLUSH cycles {5,9,0}..{8,12,0}, o_ready=0, o_done on {8,12,0}.

Source files
------------

// File: rtl/line_column_feeder.sv
// line_column_feeder
//   Turns a raster pixel stream into vertical 3-pixel columns for a 3-row
//   window operator. Two line buffers hold the previous two input lines.
//   Each accepted pixel reads both buffers at its column before they are
//   updated. That read yields {line y-2, line y-1, current pixel} for the
//   same column x.
//
// Parameters
//   IMG_WIDTH   pixels per line (>=2)
//   IMG_HEIGHT  lines per frame (>=3)
//
// Ports
//   clk      single clock, rising edge
//   reset    asynchronous, active-low
//   i_valid  input pixel present
//   i_data   8-bit pixel, raster order
//   i_done   last pixel of frame; sampled only with i_valid
//   o_ready  input can be accepted this cycle
//   o_valid  o_data holds a column
//   o_data   {[23:16] row r-1, [15:8] row r, [7:0] row r+1}
//   o_done   pulse with the last column of a frame
//   o_err    sticky frame-length mismatch flag
//
// Build option
//   LINE_COLUMN_FEEDER_PAD_EN
//     Produces a full IMG_WIDTH x IMG_HEIGHT output with zero top and
//     bottom borders. A FLUSH phase emits the final row after the frame.
module line_column_feeder #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_done,
  output logic        o_ready,
  output logic        o_valid,
  output logic [23:0] o_data,
  output logic        o_done,
  output logic        o_err
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

`ifdef LINE_COLUMN_FEEDER_PAD_EN
  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_e;
`else
  typedef enum logic [1:0] {FILL, STREAM} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [23:0]     data_q, data_d;

  // lb1 holds line y-1 and lb2 holds line y-2 relative to the input line.
  logic [7:0]      lb1_q [IMG_WIDTH];
  logic [7:0]      lb2_q [IMG_WIDTH];
  logic [7:0]      rd1, rd2;
  logic            lb_we;
  logic            accept;

  assign accept = i_valid && ready_q;
  // Combinational reads see pre-write contents, because the write lands at the clock edge.
  assign rd1    = lb1_q[col_q];
  assign rd2    = lb2_q[col_q];

  // Writing a column shifts its line history down one line.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb1_q[col_q] <= i_data;
      lb2_q[col_q] <= rd1;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    data_d  = data_q;
    lb_we   = 1'b0;
    ready_d = 1'b1;

    case (state_q)
      FILL, STREAM: begin
        if (accept) begin
          lb_we = 1'b1;
`ifdef LINE_COLUMN_FEEDER_PAD_EN
          // Row 1 already yields centre row 0, and its top neighbour is a zero border.
          if (row_q != '0) begin
            valid_d = 1'b1;
            data_d  = {(row_q == ROW_ONE) ? 8'd0 : rd2, rd1, i_data};
          end
`else
          if (state_q == STREAM) begin
            valid_d = 1'b1;
            data_d  = {rd2, rd1, i_data};
          end
`endif
          if (col_q == COL_LAST && row_q == ROW_LAST) begin
            // This pixel is the nominal end of the frame.
            // A missing i_done here is an error, but the frame still closes.
            if (!i_done) err_d = 1'b1;
            col_d = '0;
            row_d = '0;
`ifdef LINE_COLUMN_FEEDER_PAD_EN
            state_d = FLUSH;
`else
            state_d = FILL;
            done_d  = 1'b1;
`endif
          end else if (i_done) begin
            // An early i_done aborts the frame with no o_done pulse.
            err_d   = 1'b1;
            col_d   = '0;
            row_d   = '0;
            state_d = FILL;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_ONE) state_d = STREAM;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
`ifdef LINE_COLUMN_FEEDER_PAD_EN
      FLUSH: begin
        // The last input line now sits in lb1, with its upper neighbour in lb2.
        // The bottom border below it is zero.
        valid_d = 1'b1;
        data_d  = {rd2, rd1, 8'd0};
        if (col_q == COL_LAST) begin
          col_d   = '0;
          done_d  = 1'b1;
          state_d = FILL;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
`endif
      default: state_d = FILL;
    endcase

`ifdef LINE_COLUMN_FEEDER_PAD_EN
    ready_d = (state_d != FLUSH);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_done  = done_q;
  assign o_err   = err_q;
endmodule
